// File: rtl/mem_req_sched.sv
// mem_req_sched
//
// Purpose:
//   Schedules 64-byte line requests from the instruction cache and the data
//   cache onto a single-outstanding downstream line-transfer engine. One
//   request is accepted at a time. Its address, direction and write data are
//   latched and presented downstream. The completion and any read data are
//   routed back to whichever cache owns the transaction. The data cache has
//   priority, but an aging counter lets a waiting instruction fetch override
//   that priority so instruction fetch cannot be starved.
//
// Ports:
//   clk, reset        clock; asynchronous active-high reset
//   i_req/i_ack       icache level request, one-cycle accept pulse
//   i_addr            icache line address
//   i_data/i_done     icache fill data (held) and one-cycle completion pulse
//   d_req/d_ack       dcache level request, one-cycle accept pulse
//   d_we              dcache direction: 1 = writeback, 0 = fill
//   d_addr, d_wdata   dcache line address and writeback data
//   d_rdata/d_done    dcache fill data (held) and one-cycle completion pulse
//   m_req/m_ack       downstream request (held until m_ack) and accept
//   m_we, m_addr      downstream direction and line-aligned address
//   m_wdata           downstream write data
//   m_rdata/m_done    downstream read data and completion
//   busy              high whenever a transaction is in progress
module mem_req_sched #(
    parameter int STARVE_LIMIT = 8,
    parameter int LINE_W       = 512
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    output logic              i_ack,
    input  logic [63:0]       i_addr,
    output logic [LINE_W-1:0] i_data,
    output logic              i_done,
    input  logic              d_req,
    output logic              d_ack,
    input  logic              d_we,
    input  logic [63:0]       d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_done,
    output logic              m_req,
    input  logic              m_ack,
    output logic              m_we,
    output logic [63:0]       m_addr,
    output logic [LINE_W-1:0] m_wdata,
    input  logic [LINE_W-1:0] m_rdata,
    input  logic              m_done,
    output logic              busy
);

    localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } state_t;

    state_t            state;
    state_t            state_next;
    logic              owner_d;
    logic [WAIT_W-1:0] i_wait;
    logic              i_starved;
    logic              sel_i;
    logic              sel_d;

    assign i_starved = (i_wait >= WAIT_W'(STARVE_LIMIT));
    assign busy      = (state != IDLE);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and owner selection. Arbitration only happens in IDLE:
    // a starved icache beats the dcache, otherwise the dcache wins.
    always_comb begin
        state_next = state;
        sel_i      = 1'b0;
        sel_d      = 1'b0;
        case (state)
            IDLE: begin
                if (i_req && i_starved) begin
                    sel_i = 1'b1;
                end else if (d_req) begin
                    sel_d = 1'b1;
                end else if (i_req) begin
                    sel_i = 1'b1;
                end
                if (sel_i || sel_d) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (m_ack) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (m_done) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Request latching, downstream handshake and completion routing.
    // Ack/done are single-cycle pulses, so they default low every cycle.
    // A writeback completion pulses d_done but leaves d_rdata untouched.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner_d <= 1'b0;
            i_ack   <= 1'b0;
            d_ack   <= 1'b0;
            i_done  <= 1'b0;
            d_done  <= 1'b0;
            m_req   <= 1'b0;
            m_we    <= 1'b0;
            m_addr  <= '0;
            m_wdata <= '0;
            i_data  <= '0;
            d_rdata <= '0;
        end else begin
            i_ack  <= sel_i;
            d_ack  <= sel_d;
            i_done <= 1'b0;
            d_done <= 1'b0;
            if (sel_i || sel_d) begin
                owner_d <= sel_d;
                m_req   <= 1'b1;
                m_addr  <= (sel_d ? d_addr : i_addr) & ~64'h3F;
                m_we    <= sel_d && d_we;
                m_wdata <= (sel_d && d_we) ? d_wdata : '0;
            end
            if ((state == ISSUE) && m_ack) begin
                m_req <= 1'b0;
            end
            if ((state == WAIT) && m_done) begin
                if (owner_d) begin
                    d_done <= 1'b1;
                    if (!m_we) begin
                        d_rdata <= m_rdata;
                    end
                end else begin
                    i_done <= 1'b1;
                    i_data <= m_rdata;
                end
            end
        end
    end

    // Icache aging counter: counts cycles an icache request has been seen
    // without being granted, in every state, saturating at the limit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            i_wait <= '0;
        end else if (!i_req || sel_i) begin
            i_wait <= '0;
        end else if (!i_starved) begin
            i_wait <= i_wait + WAIT_W'(1);
        end
    end

endmodule

// File: doc/mem_req_sched.md
# mem_req_sched

Line-request scheduler between the instruction cache, the data cache and the single-outstanding line-transfer engine in front of the system bus. It accepts one 64-byte line request at a time from either cache and latches its address, direction and write data. It issues the request downstream, routes the completion and read data back to the owner, and arbitrates data-first with an aging override so instruction fetch cannot starve.

## Interface
- STARVE_LIMIT, 8: cycles an icache request may wait before it overrides dcache priority (≥1)
- LINE_W, 512: line width in bits
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- i_req  in  1  icache line-read request, level
- i_ack  out  1  one-cycle pulse: icache request accepted
- i_addr  in  64  icache line address
- i_data  out  LINE_W  icache fill data, valid while i_done=1, held until next icache completion
- i_done  out  1  one-cycle pulse: icache fill complete
- d_req  in  1  dcache line request, level
- d_ack  out  1  one-cycle pulse: dcache request accepted
- d_we  in  1  1=line writeback, 0=line fill
- d_addr  in  64  dcache line address
- d_wdata  in  LINE_W  writeback data
- d_rdata  out  LINE_W  dcache fill data, valid while d_done=1, held until next dcache read completion
- d_done  out  1  one-cycle pulse: dcache transaction complete
- m_req  out  1  downstream request, held until m_ack
- m_ack  in  1  downstream accepted request
- m_we  out  1  downstream direction
- m_addr  out  64  downstream address, bits [5:0] forced to 0
- m_wdata  out  LINE_W  downstream write data
- m_rdata  in  LINE_W  downstream read data, valid with m_done
- m_done  in  1  downstream transaction complete
- busy  out  1  1 whenever state ≠ IDLE

## Operation
- States: IDLE, ISSUE, WAIT.
- IDLE, owner selection evaluated every cycle:
  - icache if i_req && i_wait ≥ STARVE_LIMIT;
  - else dcache if d_req;
  - else icache if i_req;
  - else stay.
- On selection: latch owner, m_addr={addr[63:6],6'b0}, m_we (d_we for dcache, 0 for icache), m_wdata (d_wdata for dcache writes, else 0); pulse owner ack; m_req←1; go ISSUE.
- ISSUE: m_req held, latched fields stable. On m_ack=1: m_req←0, go WAIT.
- WAIT: on m_done=1:
  - read: copy m_rdata into owner's data register;
  - pulse owner done (write: d_done only, d_rdata unchanged);
  - go IDLE.
- m_ack outside ISSUE and m_done outside WAIT are ignored.
- Requests are sampled only in IDLE. A requester drops req after ack and re-requests only after its done. Levels seen in ISSUE/WAIT have no effect.
- i_wait counter, width $clog2(STARVE_LIMIT+1):
  - cleared when i_req=0 or icache is selected;
  - otherwise increments each cycle i_req=1, saturating at STARVE_LIMIT;
  - counts in all states.
- Reset (any state, including mid-transaction): state←IDLE, i_wait←0. All outputs 0, including data registers and m_addr/m_wdata. An in-flight downstream transaction is abandoned, and m_done arriving after reset is ignored.

## Timing
- Selection at edge N: ack=1, m_req=1, busy=1 during cycle N+1. Request-to-m_req latency is 1 cycle.
- m_ack high in cycle K: m_req=0 from cycle K+1.
- m_done high in cycle J: done pulse, data register valid, state IDLE all in cycle J+1. A new selection can occur at the edge ending J+1, giving m_req in J+2.
- m_ack and m_done in the same ISSUE cycle: the m_ack is taken, and that m_done is ignored.
- Simultaneous i_req and d_req with i_wait < STARVE_LIMIT: dcache wins. With i_wait = STARVE_LIMIT: icache wins.
- Ack and done are never asserted for both caches in the same cycle.

## Test plan
- Idle request: reset, then i_req=1 with i_addr=0x1007F. Expect i_ack one cycle later with m_req=1, m_addr=0x10040, m_we=0. m_ack 2 cycles later drops m_req. m_done with m_rdata=pattern A gives i_done=1 for one cycle and i_data=A.
- Dcache writeback: d_req=1, d_we=1, d_wdata=B, d_addr=0x2000. Expect m_we=1, m_wdata=B. On m_done, expect d_done=1 with d_rdata unchanged and i_done=0.
- Priority: i_req and d_req asserted in the same cycle after reset. Expect d_ack first, and i_ack at the first IDLE selection after d_done.
- Starvation (STARVE_LIMIT=4): d_req held high continuously, and each downstream transaction takes ≥4 cycles. i_req held from t0. Expect the icache selected at the second IDLE arbitration even though d_req=1, and i_wait=0 afterwards.
- Reset mid-transaction: assert reset in WAIT. Expect all outputs 0 immediately. A late m_done after release produces no done pulse, and a fresh d_req completes normally.
- Stray handshakes: m_ack in IDLE and m_done in ISSUE produce no state change or pulses.
